// File: rtl/de_buf_pkg.sv
// Shared types and default widths for the Decode/Execute pipeline buffer.
package de_buf_pkg;

  localparam int DEF_CTRL_W = 11;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_FUNC_W = 3;

  // EMPTY: nothing held; ONE: main only; FULL: main and skid both hold a beat.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_ADDR_W-1:0] waddr;
    logic [DEF_FUNC_W-1:0] func;
  } payload_t;

endpackage

// File: rtl/de_buf_slot.sv
// One payload register of the buffer: load-enabled, asynchronously cleared.
module de_buf_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/de_pipe_buffer.sv
// Decode/Execute pipeline buffer: main slot drives Execute, skid slot absorbs
// one beat of backpressure so in_ready can come straight from a flop.
module de_pipe_buffer
  import de_buf_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [FUNC_W-1:0] func_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [ADDR_W-1:0] waddr_out,
  output logic [FUNC_W-1:0] func_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = CTRL_W + 2 * DATA_W + ADDR_W + FUNC_W;

  // Handshake: a beat moves on a rising edge when valid and ready are both
  // high in the cycle before it; valid never depends on ready on either side.

  state_t             state;
  state_t             state_nxt;
  logic               ready_q;
  logic               main_valid;
  logic               accept;
  logic               emit;
  logic               load_main;
  logic               load_skid;
  logic               main_from_skid;
  logic [PAY_W-1:0]   in_pay;
  logic [PAY_W-1:0]   main_d;
  logic [PAY_W-1:0]   main_pay;
  logic [PAY_W-1:0]   skid_pay;
  logic [CTRL_W-1:0]  main_ctrl;

  assign main_valid = (state != EMPTY);
  assign accept     = in_valid & ready_q;
  assign emit       = main_valid & out_ready;
  assign in_pay     = {ctrl_in, rd1_in, rd2_in, waddr_in, func_in};
  assign main_d     = main_from_skid ? skid_pay : in_pay;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (emit) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_nxt      = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ready tracks the next state so it is already low in the first FULL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  de_buf_slot #(.W(PAY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (main_pay)
  );

  de_buf_slot #(.W(PAY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_pay),
    .q    (skid_pay)
  );

  assign {main_ctrl, rd1_out, rd2_out, waddr_out, func_out} = main_pay;
  assign ctrl_out  = main_valid ? main_ctrl : '0;
  assign out_valid = main_valid;
  assign in_ready  = ready_q;

endmodule

// File: tb/tb_de_pipe_buffer.sv
// Self-checking bench for de_pipe_buffer: hand vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_de_pipe_buffer;

  localparam int CTRL_W = 11;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int FUNC_W = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [ADDR_W-1:0] waddr;
    logic [FUNC_W-1:0] func;
  } pay_t;

  typedef struct {
    logic              iv;
    logic              ordy;
    logic              fl;
    pay_t              p;
    logic              ov;
    logic              ir;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd1;
    logic [CNT_W-1:0]  st;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] rd1_in;
  logic [DATA_W-1:0] rd2_in;
  logic [ADDR_W-1:0] waddr_in;
  logic [FUNC_W-1:0] func_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] rd1_out;
  logic [DATA_W-1:0] rd2_out;
  logic [ADDR_W-1:0] waddr_out;
  logic [FUNC_W-1:0] func_out;
  logic [CNT_W-1:0]  stall_cnt;

  pay_t exp_q[$];
  int   m_cnt;
  int   n_cmp;
  int   n_err;
  vec_t tbl[15];

  de_pipe_buffer #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FUNC_W(FUNC_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_in   (ctrl_in),
    .rd1_in    (rd1_in),
    .rd2_in    (rd2_in),
    .waddr_in  (waddr_in),
    .func_in   (func_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_out  (ctrl_out),
    .rd1_out   (rd1_out),
    .rd2_out   (rd2_out),
    .waddr_out (waddr_out),
    .func_out  (func_out),
    .stall_cnt (stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t mkp(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] r1);
    pay_t p;
    p.ctrl  = c;
    p.rd1   = r1;
    p.rd2   = ~r1;
    p.waddr = c[2:0];
    p.func  = c[5:3];
    return p;
  endfunction

  function automatic vec_t mkv(input logic iv, input logic ordy, input logic fl, input pay_t p,
                               input logic ov, input logic ir, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] r1, input logic [CNT_W-1:0] st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.p = p;
    v.ov = ov; v.ir = ir; v.ctrl = c; v.rd1 = r1; v.st = st;
    return v;
  endfunction

  // Reference model: the buffer is a FIFO of at most two beats.
  task automatic model_edge();
    bit stall;
    bit acc;
    bit em;
    pay_t cur;
    cur   = '{ctrl: ctrl_in, rd1: rd1_in, rd2: rd2_in, waddr: waddr_in, func: func_in};
    stall = (exp_q.size() > 0) && !out_ready;
    if (stall && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      exp_q.delete();
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      em  = (exp_q.size() > 0) && out_ready;
      if (em) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(cur);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ":out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    check({tag, ":in_ready"}, 32'(in_ready), 32'(exp_q.size() < 2));
    check({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    if (exp_q.size() > 0) begin
      check({tag, ":ctrl_out"}, 32'(ctrl_out), 32'(exp_q[0].ctrl));
      check({tag, ":rd1_out"}, 32'(rd1_out), 32'(exp_q[0].rd1));
      check({tag, ":rd2_out"}, 32'(rd2_out), 32'(exp_q[0].rd2));
      check({tag, ":waddr_out"}, 32'(waddr_out), 32'(exp_q[0].waddr));
      check({tag, ":func_out"}, 32'(func_out), 32'(exp_q[0].func));
    end else begin
      check({tag, ":ctrl_bubble"}, 32'(ctrl_out), 32'd0);
    end
  endtask

  // driver: inputs change 1 time unit after an edge, outputs read at the same point
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input pay_t p, input string tag);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    ctrl_in   = p.ctrl;
    rd1_in    = p.rd1;
    rd2_in    = p.rd2;
    waddr_in  = p.waddr;
    func_in   = p.func;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    in_valid = 1'b0;
    flush    = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_cnt = 0;
    check({tag, ":rst_stall_cnt"}, 32'(stall_cnt), 32'd0);
    check({tag, ":rst_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":rst_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":rst_ctrl_out"}, 32'(ctrl_out), 32'd0);
    check({tag, ":rst_rd1_out"}, 32'(rd1_out), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    pay_t p;
    n_cmp = 0;
    n_err = 0;
    m_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    ctrl_in = '0; rd1_in = '0; rd2_in = '0; waddr_in = '0; func_in = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:in_ready", 32'(in_ready), 32'd1);
    check("reset:ctrl_out", 32'(ctrl_out), 32'd0);
    check("reset:rd1_out", 32'(rd1_out), 32'd0);
    check("reset:rd2_out", 32'(rd2_out), 32'd0);
    check("reset:waddr_out", 32'(waddr_out), 32'd0);
    check("reset:func_out", 32'(func_out), 32'd0);
    check("reset:stall_cnt", 32'(stall_cnt), 32'd0);
    #2;
    rst = 1'b0;

    // single pass, backpressure A/B/C, flush in FULL, emit coinciding with flush
    p = '{ctrl: 11'h5A5, rd1: 16'h1234, rd2: 16'hBEEF, waddr: 3'd5, func: 3'd6};
    tbl[0]  = mkv(1, 1, 0, p,                     1, 1, 11'h5A5, 16'h1234, 4'd0);
    tbl[1]  = mkv(0, 1, 0, '0,                    0, 1, 11'h000, 16'h0000, 4'd0);
    tbl[2]  = mkv(1, 0, 0, mkp(11'h001, 16'hA),   1, 1, 11'h001, 16'h000A, 4'd0);
    tbl[3]  = mkv(1, 0, 0, mkp(11'h002, 16'hB),   1, 0, 11'h001, 16'h000A, 4'd1);
    tbl[4]  = mkv(1, 0, 0, mkp(11'h003, 16'hC),   1, 0, 11'h001, 16'h000A, 4'd2);
    tbl[5]  = mkv(1, 1, 0, mkp(11'h003, 16'hC),   1, 1, 11'h002, 16'h000B, 4'd2);
    tbl[6]  = mkv(1, 1, 0, mkp(11'h003, 16'hC),   1, 1, 11'h003, 16'h000C, 4'd2);
    tbl[7]  = mkv(0, 1, 0, '0,                    0, 1, 11'h000, 16'h0000, 4'd2);
    tbl[8]  = mkv(1, 0, 0, mkp(11'h004, 16'hD),   1, 1, 11'h004, 16'h000D, 4'd2);
    tbl[9]  = mkv(1, 0, 0, mkp(11'h005, 16'hE),   1, 0, 11'h004, 16'h000D, 4'd3);
    tbl[10] = mkv(1, 0, 1, mkp(11'h006, 16'hF),   0, 1, 11'h000, 16'h0000, 4'd4);
    tbl[11] = mkv(0, 1, 0, '0,                    0, 1, 11'h000, 16'h0000, 4'd4);
    tbl[12] = mkv(1, 1, 0, mkp(11'h007, 16'h10),  1, 1, 11'h007, 16'h0010, 4'd4);
    tbl[13] = mkv(1, 1, 1, mkp(11'h008, 16'h11),  0, 1, 11'h000, 16'h0000, 4'd4);
    tbl[14] = mkv(0, 1, 0, '0,                    0, 1, 11'h000, 16'h0000, 4'd4);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].p, $sformatf("vec%0d", i));
      check($sformatf("vec%0d:tbl_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("vec%0d:tbl_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      check($sformatf("vec%0d:tbl_ctrl_out", i), 32'(ctrl_out), 32'(tbl[i].ctrl));
      check($sformatf("vec%0d:tbl_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].st));
      if (tbl[i].ov) check($sformatf("vec%0d:tbl_rd1_out", i), 32'(rd1_out), 32'(tbl[i].rd1));
    end

    // streaming: eight back-to-back beats at full rate
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, mkp(11'h40 + 11'(i), 16'(i)), $sformatf("stream%0d", i));
      check($sformatf("stream%0d:valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d:rd1", i), 32'(rd1_out), 32'(i));
    end
    cycle(0, 1, 0, '0, "stream_end");
    check("stream_end:valid", 32'(out_valid), 32'd0);

    // saturation of the stall counter, then asynchronous reset mid-stall
    cycle(1, 0, 0, mkp(11'h7FF, 16'h5555), "sat_load");
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, "sat");
    check("sat:stall_cnt_max", 32'(stall_cnt), 32'(CNT_MAX));
    async_reset("midstall");

    // randomized traffic with occasional mid-run resets
    for (int i = 0; i < 600; i++) begin
      p.ctrl  = 11'($urandom);
      p.rd1   = 16'($urandom);
      p.rd2   = 16'($urandom);
      p.waddr = 3'($urandom);
      p.func  = 3'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, p, "rand");
      if (i % 150 == 149) async_reset("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
